// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end with RMW sub-doubleword stores
// Optional upper-address bounds check enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_access_unit #(
  parameter int WORD_INDEX_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_address,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LD, RMW_RD, WR, DONE} state_t;

  state_t      state, state_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] wdata_q, wdata_d;
  logic        mem_read_d, mem_write_d;
  logic [63:0] mem_address_d, mem_wdata_d;
  logic        resp_valid_d, resp_err_d;
  logic [63:0] resp_rdata_d;
  logic        misaligned, out_of_range;

  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] word, input logic [1:0] sz,
                                          input logic sg, input logic [2:0] off);
    logic [63:0] sh;
    sh = (word >> {off, 3'b000}) & size_mask(sz);
    if (sg) begin
      case (sz)
        2'b00:   sh = {{56{sh[7]}}, sh[7:0]};
        2'b01:   sh = {{48{sh[15]}}, sh[15:0]};
        2'b10:   sh = {{32{sh[31]}}, sh[31:0]};
        default: sh = sh;
      endcase
    end
    extract = sh;
  endfunction

  // Replace only the addressed lane(s); every other byte of the old word survives.
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                        input logic [1:0] sz, input logic [2:0] off);
    logic [63:0] lane;
    lane  = size_mask(sz) << {off, 3'b000};
    merge = (old & ~lane) | ((data & size_mask(sz)) << {off, 3'b000});
  endfunction

  always_comb begin
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

`ifdef MEM_BOUNDS_CHECK_EN
  assign out_of_range = |req_addr[63:WORD_INDEX_BITS+3];
`else
  logic unused_upper;
  assign unused_upper = |req_addr[63:WORD_INDEX_BITS+3];
  assign out_of_range = 1'b0;
`endif

  assign req_ready = (state == IDLE);

  always_comb begin
    state_d       = state;
    size_d        = size_q;
    signed_d      = signed_q;
    off_d         = off_q;
    wdata_d       = wdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address;
    mem_wdata_d   = mem_wdata;
    resp_valid_d  = 1'b0;
    resp_err_d    = resp_err;
    resp_rdata_d  = resp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          size_d   = req_size;
          signed_d = req_signed;
          off_d    = req_addr[2:0];
          wdata_d  = req_wdata;
          if (misaligned || out_of_range) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 64'd0;
          end else begin
            mem_address_d = {3'b000, req_addr[63:3]};
            if (!req_write) begin
              state_d    = LD;
              mem_read_d = 1'b1;
            end else if (req_size == 2'b11) begin
              state_d     = WR;
              mem_write_d = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d    = RMW_RD;
              mem_read_d = 1'b1;
            end
          end
        end
      end
      LD: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = extract(mem_rdata, size_q, signed_q, off_q);
      end
      RMW_RD: begin
        state_d     = WR;
        mem_write_d = 1'b1;
        mem_wdata_d = merge(mem_rdata, wdata_q, size_q, off_q);
      end
      WR: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 64'd0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Async clear of mem_write drops an in-flight store write the instant reset falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      off_q       <= 3'd0;
      wdata_q     <= 64'd0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= 64'd0;
      mem_wdata   <= 64'd0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= 64'd0;
    end else begin
      state       <= state_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      mem_read    <= mem_read_d;
      mem_write   <= mem_write_d;
      mem_address <= mem_address_d;
      mem_wdata   <= mem_wdata_d;
      resp_valid  <= resp_valid_d;
      resp_err    <= resp_err_d;
      resp_rdata  <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int WIB = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic [63:0] mem [0:1023];
  logic [7:0]  ref_bytes [0:8191];
  logic        do_init = 1'b1;
  int          n_assert = 0;
  int          n_fail = 0;

  mem_access_unit #(.WORD_INDEX_BITS(WIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_value(input int i);
    case (i)
      0:       init_value = 64'd1;
      1:       init_value = 64'd10;
      4:       init_value = 64'h0123_4567_89AB_CDEF;
      default: init_value = 64'd0;
    endcase
  endfunction

  assign mem_rdata = mem[mem_address[WIB-1:0]];

  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_value(i);
    end else if (mem_write) begin
      mem[mem_address[WIB-1:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-array reference: the memory is just 8 KiB of bytes seen through a 13-bit window.
  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic err, output int lat,
                       output int nrd, output int nwr);
    int n;
    logic mis, oob;
    n   = 1 << sz;
    mis = (a % n) != 0;
`ifdef MEM_BOUNDS_CHECK_EN
    oob = (a >> (WIB + 3)) != 0;
`else
    oob = 1'b0;
`endif
    rd = 64'd0; err = mis || oob; lat = 1; nrd = 0; nwr = 0;
    if (!err) begin
      if (!w) begin
        for (int i = 0; i < n; i++) rd = rd | (64'(ref_bytes[(a[12:0] + i) % 8192]) << (8 * i));
        if (sg && n < 8 && rd[8 * n - 1]) rd = rd | (~64'd0 << (8 * n));
        lat = 2; nrd = 1;
      end else begin
        for (int i = 0; i < n; i++) ref_bytes[(a[12:0] + i) % 8192] = 8'(wd >> (8 * i));
        lat = (sz == 2'b11) ? 2 : 3;
        nrd = (sz == 2'b11) ? 0 : 1;
        nwr = 1;
      end
    end
  endtask

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [63:0] a, input logic [63:0] wd,
                         output logic [63:0] rd, output logic err, output int lat,
                         output int nrd, output int nwr, output logic side_ok);
    int waited;
    waited = 0;
    rd = 64'd0; err = 1'b0; lat = 99; nrd = 0; nwr = 0; side_ok = 1'b1;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("req_ready_before_req", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = $urandom_range(0, 1); req_size = 2'($urandom);
    req_signed = $urandom_range(0, 1); req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    for (int c = 1; c <= 10; c++) begin
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if ((mem_read || mem_write) && mem_address !== {3'b000, a[63:3]}) side_ok = 1'b0;
      if (mem_read && mem_write) side_ok = 1'b0;
      if (resp_valid) begin
        rd = resp_rdata; err = resp_err; lat = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk("resp_valid_single_pulse", {63'd0, resp_valid}, 64'd0);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [63:0] rd, m_rd, old4;
    logic        err, m_err, side_ok, w, sg;
    logic [1:0]  sz;
    logic [63:0] a, wd;
    int          lat, nrd, nwr, m_lat, m_nrd, m_nwr;

    for (int i = 0; i < 1024; i++)
      for (int b = 0; b < 8; b++) ref_bytes[8 * i + b] = init_value(i)[8 * b +: 8];

    tbl.push_back('{1'b0, 2'b11, 1'b0, 64'h08, 64'h0, 64'd10, 1'b0, 2});
    tbl.push_back('{1'b1, 2'b00, 1'b0, 64'h0F, 64'h80, 64'h0, 1'b0, 3});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 64'h0F, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b0, 64'h0F, 64'h0, 64'h80, 1'b0, 2});
    tbl.push_back('{1'b1, 2'b01, 1'b0, 64'h00, 64'hBEEF, 64'h0, 1'b0, 3});
    tbl.push_back('{1'b0, 2'b10, 1'b1, 64'h00, 64'h0, 64'hBEEF, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 64'h06, 64'h0, 64'h0, 1'b1, 1});
`ifdef MEM_BOUNDS_CHECK_EN
    tbl.push_back('{1'b0, 2'b11, 1'b0, 64'h2000, 64'h0, 64'h0, 1'b1, 1});
`else
    tbl.push_back('{1'b0, 2'b11, 1'b0, 64'h2000, 64'h0, 64'hBEEF, 1'b0, 2});
`endif
    tbl.push_back('{1'b1, 2'b11, 1'b0, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b1, 64'h16, 64'h0, 64'h1122, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b00, 1'b1, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b10, 1'b0, 64'h14, 64'h0, 64'h1122_3344, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b01, 1'b0, 64'h11, 64'h0, 64'h0, 1'b1, 1});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 64'h12, 64'hDEAD, 64'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 64'h14, 64'h0, 64'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 2'b10, 1'b1, 64'h08, 64'h0, 64'hA, 1'b0, 2});
    tbl.push_back('{1'b0, 2'b10, 1'b1, 64'h0C, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0, 2});
    tbl.push_back('{1'b1, 2'b10, 1'b0, 64'h18, 64'hFFFF_FFFF_CAFE_F00D, 64'h0, 1'b0, 3});
    tbl.push_back('{1'b0, 2'b11, 1'b0, 64'h18, 64'h0, 64'hCAFE_F00D, 1'b0, 2});

    repeat (2) @(negedge clk);
    do_init = 1'b0;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
    chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
    chk("rst_mem_address", mem_address, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      model(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, m_rd, m_err, m_lat, m_nrd, m_nwr);
      run_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, rd, err, lat, nrd, nwr, side_ok);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {63'd0, err}, {63'd0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_mem_reads", i), 64'(nrd), 64'(m_nrd));
      chk($sformatf("tbl%0d_mem_writes", i), 64'(nwr), 64'(m_nwr));
      chk($sformatf("tbl%0d_mem_side", i), {63'd0, side_ok}, 64'd1);
    end
    chk("mem1_after_byte_store", mem[1], 64'h8000_0000_0000_000A);
    chk("mem0_after_half_store", mem[0], 64'h0000_0000_0000_BEEF);
    chk("mem2_after_double_store", mem[2], 64'h1122_3344_5566_7788);

    // Reset asserted during the WR cycle of a byte RMW store.
    old4 = mem[4];
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 64'h21; req_wdata = 64'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_rd_mem_read", {63'd0, mem_read}, 64'd1);
    @(negedge clk);
    chk("rmw_wr_mem_write", {63'd0, mem_write}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_mem_write", {63'd0, mem_write}, 64'd0);
    chk("rst_drops_resp_valid", {63'd0, resp_valid}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("no_resp_in_reset", {63'd0, resp_valid}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, req_ready}, 64'd1);
    chk("no_resp_after_reset", {63'd0, resp_valid}, 64'd0);
    chk("mem4_unchanged", mem[4], old4);

    for (int k = 0; k < 200; k++) begin
      w  = $urandom_range(0, 1);
      sz = 2'($urandom_range(0, 3));
      sg = $urandom_range(0, 1);
      a  = 64'($urandom_range(0, 127));
      if ($urandom_range(0, 4) == 0) a = a | ({$urandom, $urandom} << 13);
      if ($urandom_range(0, 2) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      wd = {$urandom, $urandom};
      model(w, sz, sg, a, wd, m_rd, m_err, m_lat, m_nrd, m_nwr);
      run_req(w, sz, sg, a, wd, rd, err, lat, nrd, nwr, side_ok);
      chk($sformatf("rnd%0d_rdata", k), rd, m_rd);
      chk($sformatf("rnd%0d_err", k), {63'd0, err}, {63'd0, m_err});
      chk($sformatf("rnd%0d_latency", k), 64'(lat), 64'(m_lat));
      chk($sformatf("rnd%0d_mem_reads", k), 64'(nrd), 64'(m_nrd));
      chk($sformatf("rnd%0d_mem_writes", k), 64'(nwr), 64'(m_nwr));
      chk($sformatf("rnd%0d_mem_side", k), {63'd0, side_ok}, 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
